// File: rtl/rv32i_types.sv
//------------------------------------------------------------------------------
// Module   : rv32i_types
// Brief    : Shared CDB constants and broadcast record type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_types;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] wdata;
    } cdb_t;

endpackage

`default_nettype wire

// File: rtl/exu2cdb.sv
//------------------------------------------------------------------------------
// Module   : exu2cdb
// Brief    : Execution-unit to CDB completion handshake bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface exu2cdb
    import rv32i_types::*;
#(
    parameter int N_EXU = 4
);

    logic [N_EXU-1:0]        exu_req;
    logic [N_EXU*TAG_W-1:0]  exu_tag;
    logic [N_EXU*DATA_W-1:0] exu_wdata;
    logic [N_EXU-1:0]        exu_rdy;
    cdb_t                    cdb;

    modport responder (
        input  exu_req,
        input  exu_tag,
        input  exu_wdata,
        output exu_rdy,
        output cdb
    );

    modport requester (
        output exu_req,
        output exu_tag,
        output exu_wdata,
        input  exu_rdy,
        input  cdb
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter, search starts at ptr and wraps.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_pos;

    // One extra bit on the sum handles the wrap for non-power-of-two N.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_sum     = '0;
        w_pos     = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            w_pos = w_sum[PTR_W-1:0];
            if (!any_grant && req[w_pos]) begin
                grant[w_pos] = 1'b1;
                grant_idx    = w_pos;
                any_grant    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : cdb_arbiter
// Brief    : Round-robin CDB arbiter with a registered one-cycle broadcast.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter #(
    parameter int  N_EXU  = 4,
    parameter int  TAG_W  = rv32i_types::TAG_W,
    parameter int  DATA_W = rv32i_types::DATA_W,
    localparam int PTR_W  = $clog2(N_EXU)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_EXU-1:0]          exu_req,
    input  logic [N_EXU*TAG_W-1:0]    exu_tag,
    input  logic [N_EXU*DATA_W-1:0]   exu_wdata,
    output logic [N_EXU-1:0]          exu_rdy,
    output logic                      cdb_vld,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_wdata
);

    // Same layout as rv32i_types::cdb_t, sized by this instance's parameters.
    typedef struct packed {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] wdata;
    } bcast_t;

    logic [N_EXU-1:0]  w_req;
    logic [N_EXU-1:0]  w_grant;
    logic [PTR_W-1:0]  w_idx;
    logic              w_any;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_wdata;
    logic [PTR_W-1:0]  r_ptr;
    bcast_t            r_bcast;

    // Masking requests gives rst priority over flush and flush over grant.
    assign w_req = (rst || flush) ? '0 : exu_req;

    rr_arbiter #(
        .N     (N_EXU),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (w_req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_idx),
        .any_grant (w_any)
    );

    assign exu_rdy   = w_grant;
    assign w_ptr_nxt = (w_idx == PTR_W'(N_EXU-1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_tag   = '0;
        w_wdata = '0;
        for (int i = 0; i < N_EXU; i++) begin
            if (w_grant[i]) begin
                w_tag   = exu_tag[i*TAG_W +: TAG_W];
                w_wdata = exu_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcast <= '0;
            r_ptr   <= '0;
        end else begin
            r_bcast.vld <= w_any;
            if (w_any) begin
                r_bcast.tag   <= w_tag;
                r_bcast.wdata <= w_wdata;
                r_ptr         <= w_ptr_nxt;
            end
        end
    end

    assign cdb_vld   = r_bcast.vld;
    assign cdb_tag   = r_bcast.tag;
    assign cdb_wdata = r_bcast.wdata;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_cdb_arbiter
// Brief    : Self-checking bench for cdb_arbiter (N_EXU=4 and N_EXU=3 instances).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush;
    logic [3:0]   req4, rdy4;
    logic [15:0]  tag4;
    logic [127:0] wd4;
    logic         vld4;
    logic [3:0]   ctag4;
    logic [31:0]  cwd4;
    logic [2:0]   req3, rdy3;
    logic [11:0]  tag3;
    logic [95:0]  wd3;
    logic         vld3;
    logic [3:0]   ctag3;
    logic [31:0]  cwd3;

    int tests = 0;
    int fails = 0;
    int mptr4;

    cdb_arbiter #(.N_EXU(4), .TAG_W(4), .DATA_W(32)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .exu_req(req4), .exu_tag(tag4), .exu_wdata(wd4), .exu_rdy(rdy4),
        .cdb_vld(vld4), .cdb_tag(ctag4), .cdb_wdata(cwd4)
    );

    cdb_arbiter #(.N_EXU(3), .TAG_W(4), .DATA_W(32)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .exu_req(req3), .exu_tag(tag3), .exu_wdata(wd3), .exu_rdy(rdy3),
        .cdb_vld(vld3), .cdb_tag(ctag3), .cdb_wdata(cwd3)
    );

    // Reference: first requester found scanning upward from ptr, modulo n.
    function automatic int ref_grant(input logic [3:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            int j = (ptr + k) % n;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; flush = 1'b0; req4 = '0; req3 = '0;
        tick();
        rst = 1'b0;
        mptr4 = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0;
        req4 = 4'hF; req3 = 3'h7;
        tag4 = 16'h1234; wd4 = {4{32'hCAFE_F00D}};
        tag3 = 12'h567;  wd3 = {3{32'h0BAD_BEEF}};
        #1;
        tests++; if (rdy4 !== 4'b0) begin fails++; $display("FAIL reset_rdy4: got %b want 0000", rdy4); end
        tests++; if (rdy3 !== 3'b0) begin fails++; $display("FAIL reset_rdy3: got %b want 000", rdy3); end
        tick();
        tests++; if (vld4 !== 1'b0) begin fails++; $display("FAIL reset_vld4: got %b want 0", vld4); end
        tests++; if (ctag4 !== 4'h0) begin fails++; $display("FAIL reset_tag4: got %h want 0", ctag4); end
        tests++; if (cwd4 !== 32'h0) begin fails++; $display("FAIL reset_wdata4: got %h want 0", cwd4); end
        tests++; if (vld3 !== 1'b0 || ctag3 !== 4'h0 || cwd3 !== 32'h0) begin
            fails++; $display("FAIL reset_dut3: got vld=%b tag=%h wdata=%h want zeros", vld3, ctag3, cwd3);
        end
        req4 = '0; req3 = '0; rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        do_reset();
        req4 = 4'b0100;
        tag4 = 16'h0000; tag4[8 +: 4] = 4'd5;
        wd4 = '0; wd4[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        tests++; if (rdy4 !== 4'b0100) begin fails++; $display("FAIL single_rdy: got %b want 0100", rdy4); end
        tick();
        tests++; if (vld4 !== 1'b1 || ctag4 !== 4'd5 || cwd4 !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL single_bcast: got vld=%b tag=%h wdata=%h want 1/5/deadbeef", vld4, ctag4, cwd4);
        end
        req4 = 4'hF;
        #1;
        tests++; if (rdy4 !== 4'b1000) begin fails++; $display("FAIL single_ptr3: got %b want 1000", rdy4); end
        req4 = 4'h0;
        tick();
        tests++; if (vld4 !== 1'b0 || ctag4 !== 4'd5 || cwd4 !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL single_idle_hold: got vld=%b tag=%h wdata=%h want 0/5/deadbeef", vld4, ctag4, cwd4);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        req4 = 4'b1001;
        tag4 = '0; tag4[0 +: 4] = 4'd1; tag4[12 +: 4] = 4'd2;
        wd4 = '0; wd4[0 +: 32] = 32'hA0A0_A0A0; wd4[96 +: 32] = 32'hB3B3_B3B3;
        #1;
        tests++; if (rdy4 !== 4'b0001) begin fails++; $display("FAIL b2b_first: got %b want 0001", rdy4); end
        tick();
        req4 = 4'b1000;
        #1;
        tests++; if (vld4 !== 1'b1 || ctag4 !== 4'd1 || cwd4 !== 32'hA0A0_A0A0) begin
            fails++; $display("FAIL b2b_bcast0: got vld=%b tag=%h wdata=%h want 1/1/a0a0a0a0", vld4, ctag4, cwd4);
        end
        tests++; if (rdy4 !== 4'b1000) begin fails++; $display("FAIL b2b_second: got %b want 1000", rdy4); end
        tick();
        req4 = 4'b0000;
        tests++; if (vld4 !== 1'b1 || ctag4 !== 4'd2 || cwd4 !== 32'hB3B3_B3B3) begin
            fails++; $display("FAIL b2b_bcast3: got vld=%b tag=%h wdata=%h want 1/2/b3b3b3b3", vld4, ctag4, cwd4);
        end
        tick();
        tests++; if (vld4 !== 1'b0 || ctag4 !== 4'd2) begin
            fails++; $display("FAIL b2b_idle: got vld=%b tag=%h want 0/2", vld4, ctag4);
        end
    endtask

    task automatic test_fair_wrap;
        do_reset();
        req4 = 4'hF; req3 = 3'h7;
        for (int u = 0; u < 4; u++) begin
            tag4[u*4 +: 4]  = 4'(u + 8);
            wd4[u*32 +: 32] = 32'hA000_0000 + u;
        end
        for (int u = 0; u < 3; u++) begin
            tag3[u*4 +: 4]  = 4'(u + 4);
            wd3[u*32 +: 32] = 32'hC000_0000 + u;
        end
        for (int k = 0; k < 7; k++) begin
            #1;
            tests++; if (rdy4 !== 4'(1 << (k % 4))) begin
                fails++; $display("FAIL fair4_grant[%0d]: got %b want %b", k, rdy4, 4'(1 << (k % 4)));
            end
            tests++; if (rdy3 !== 3'(1 << (k % 3))) begin
                fails++; $display("FAIL fair3_grant[%0d]: got %b want %b", k, rdy3, 3'(1 << (k % 3)));
            end
            tick();
            tests++; if (vld4 !== 1'b1 || ctag4 !== 4'((k % 4) + 8) || cwd4 !== 32'hA000_0000 + (k % 4)) begin
                fails++; $display("FAIL fair4_bcast[%0d]: got vld=%b tag=%h wdata=%h", k, vld4, ctag4, cwd4);
            end
            tests++; if (vld3 !== 1'b1 || ctag3 !== 4'((k % 3) + 4) || cwd3 !== 32'hC000_0000 + (k % 3)) begin
                fails++; $display("FAIL fair3_bcast[%0d]: got vld=%b tag=%h wdata=%h", k, vld3, ctag3, cwd3);
            end
        end
        req4 = '0; req3 = '0;
    endtask

    task automatic test_hold;
        do_reset();
        req4 = 4'b0011;
        tag4 = '0; tag4[0 +: 4] = 4'd1; tag4[4 +: 4] = 4'd9;
        wd4 = '0; wd4[0 +: 32] = 32'h0000_0001; wd4[32 +: 32] = 32'h1111_2222;
        #1;
        tests++; if (rdy4 !== 4'b0001) begin fails++; $display("FAIL hold_first: got %b want 0001", rdy4); end
        tick();
        tag4[0 +: 4] = 4'd2; wd4[0 +: 32] = 32'h0000_0002;
        #1;
        tests++; if (rdy4 !== 4'b0010) begin fails++; $display("FAIL hold_unit1: got %b want 0010", rdy4); end
        tick();
        req4 = '0;
        tests++; if (vld4 !== 1'b1 || ctag4 !== 4'd9 || cwd4 !== 32'h1111_2222) begin
            fails++; $display("FAIL hold_bcast: got vld=%b tag=%h wdata=%h want 1/9/11112222", vld4, ctag4, cwd4);
        end
    endtask

    task automatic test_flush;
        do_reset();
        req4 = 4'b0001; tag4 = '0; wd4 = '0;
        tick();
        req4 = 4'b0110;
        tag4[4 +: 4] = 4'h7; wd4[32 +: 32] = 32'h1234_5678;
        tag4[8 +: 4] = 4'h6; wd4[64 +: 32] = 32'h8765_4321;
        flush = 1'b1;
        #1;
        tests++; if (rdy4 !== 4'b0000) begin fails++; $display("FAIL flush_rdy: got %b want 0000", rdy4); end
        tick();
        flush = 1'b0;
        tests++; if (vld4 !== 1'b0) begin fails++; $display("FAIL flush_vld: got %b want 0", vld4); end
        #1;
        tests++; if (rdy4 !== 4'b0010) begin fails++; $display("FAIL flush_resume: got %b want 0010", rdy4); end
        tick();
        req4 = '0;
        tests++; if (vld4 !== 1'b1 || ctag4 !== 4'h7 || cwd4 !== 32'h1234_5678) begin
            fails++; $display("FAIL flush_bcast: got vld=%b tag=%h wdata=%h want 1/7/12345678", vld4, ctag4, cwd4);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req4 = 4'b0100; tag4 = '0; wd4 = '0;
        tag4[8 +: 4] = 4'hE; wd4[64 +: 32] = 32'hEEEE_EEEE;
        tick();
        req4 = 4'b1010;
        tag4[12 +: 4] = 4'hC; wd4[96 +: 32] = 32'hCCCC_CCCC;
        tag4[4 +: 4]  = 4'h3; wd4[32 +: 32] = 32'h0BAD_F00D;
        #1;
        tests++; if (rdy4 !== 4'b1000) begin fails++; $display("FAIL rstmid_pending: got %b want 1000", rdy4); end
        rst = 1'b1;
        #1;
        tests++; if (rdy4 !== 4'b0000) begin fails++; $display("FAIL rstmid_rdy: got %b want 0000", rdy4); end
        tick();
        tests++; if (vld4 !== 1'b0 || ctag4 !== 4'h0 || cwd4 !== 32'h0) begin
            fails++; $display("FAIL rstmid_clear: got vld=%b tag=%h wdata=%h want zeros", vld4, ctag4, cwd4);
        end
        rst = 1'b0;
        #1;
        tests++; if (rdy4 !== 4'b0010) begin fails++; $display("FAIL rstmid_lowest: got %b want 0010", rdy4); end
        tick();
        req4 = '0;
        tests++; if (vld4 !== 1'b1 || ctag4 !== 4'h3 || cwd4 !== 32'h0BAD_F00D) begin
            fails++; $display("FAIL rstmid_bcast: got vld=%b tag=%h wdata=%h want 1/3/0badf00d", vld4, ctag4, cwd4);
        end
    endtask

    task automatic test_random;
        logic [3:0]  pend;
        logic [3:0]  tg[4];
        logic [31:0] wdv[4];
        logic [3:0]  exp_rdy;
        logic        ev;
        logic [3:0]  et;
        logic [31:0] ew;
        int          g;
        do_reset();
        pend = '0; et = '0; ew = '0;
        for (int c = 0; c < 300; c++) begin
            for (int u = 0; u < 4; u++) begin
                if (!pend[u] && $urandom_range(0, 2) != 0) begin
                    pend[u] = 1'b1;
                    tg[u]   = 4'($urandom);
                    wdv[u]  = $urandom;
                end
                if (pend[u]) begin
                    tag4[u*4 +: 4]  = tg[u];
                    wd4[u*32 +: 32] = wdv[u];
                end else begin
                    tag4[u*4 +: 4]  = 4'($urandom);
                    wd4[u*32 +: 32] = $urandom;
                end
            end
            req4  = pend;
            flush = ($urandom_range(0, 9) == 0);
            #1;
            g = flush ? -1 : ref_grant(pend, mptr4, 4);
            exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
            tests++; if (rdy4 !== exp_rdy) begin
                fails++; $display("FAIL rand_rdy[%0d]: got %b want %b", c, rdy4, exp_rdy);
            end
            ev = (g >= 0);
            if (g >= 0) begin
                et = tg[g]; ew = wdv[g];
                mptr4 = (g + 1) % 4;
                pend[g] = 1'b0;
            end
            tick();
            tests++; if (vld4 !== ev || ctag4 !== et || cwd4 !== ew) begin
                fails++; $display("FAIL rand_bcast[%0d]: got vld=%b tag=%h wdata=%h want %b/%h/%h",
                                  c, vld4, ctag4, cwd4, ev, et, ew);
            end
        end
        flush = 1'b0; req4 = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        req4 = '0; tag4 = '0; wd4 = '0;
        req3 = '0; tag3 = '0; wd3 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fair_wrap();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
